// File: rtl/booth_mul_pkg.sv
// rtl/booth_mul_pkg.sv - shared types and helpers for the radix-4 Booth sequential multiplier
package booth_mul_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  typedef enum logic [2:0] {
    ZERO,
    POS1,
    POS2,
    NEG1,
    NEG2
  } booth_sel_e;

  // Triple is {b[2i+1], b[2i], b[2i-1]}
  function automatic booth_sel_e booth_decode(input logic [2:0] triple);
    booth_sel_e sel;
    case (triple)
      3'b001, 3'b010: sel = POS1;
      3'b011:         sel = POS2;
      3'b100:         sel = NEG2;
      3'b101, 3'b110: sel = NEG1;
      default:        sel = ZERO;
    endcase
    return sel;
  endfunction

  // ceil((width/2 + 1) / pp)
  function automatic int booth_iters(input int width, input int pp);
    return (width / 2 + pp) / pp;
  endfunction

endpackage

// File: rtl/booth_r4_enc.sv
// rtl/booth_r4_enc.sv - radix-4 Booth digit to signed multiple of the extended multiplicand
module booth_r4_enc
  import booth_mul_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       triple,
  input  logic [WIDTH+1:0] a_ext,
  output logic [WIDTH+2:0] multiple
);

  logic [WIDTH+2:0] a1;
  logic [WIDTH+2:0] a2;
  logic [WIDTH+2:0] one;

  assign a1  = {a_ext[WIDTH+1], a_ext};
  assign a2  = {a_ext, 1'b0};
  assign one = {{(WIDTH+2){1'b0}}, 1'b1};

  // Negation is invert-plus-one; one guard bit keeps -2a exact for the most-negative a
  always_comb begin
    multiple = '0;
    case (booth_decode(triple))
      POS1:    multiple = a1;
      POS2:    multiple = a2;
      NEG1:    multiple = ~a1 + one;
      NEG2:    multiple = ~a2 + one;
      default: multiple = '0;
    endcase
  end

endmodule

// File: rtl/booth_mul_seq.sv
// rtl/booth_mul_seq.sv - iterative radix-4 Booth multiplier with start/done handshake
module booth_mul_seq
  import booth_mul_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int PP_PER_CYCLE = 1
) (
  input  logic                 clk,
  input  logic                 clr_n,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int DIGITS = WIDTH / 2 + 1;
  localparam int N_ITER = booth_iters(WIDTH, PP_PER_CYCLE);
  localparam int CNT_W  = $clog2(N_ITER + 1);
  // Multiplier shift register must expose a full triple for every slot
  localparam int BS_W   = (WIDTH + 3 > 2 * PP_PER_CYCLE + 1) ? WIDTH + 3 : 2 * PP_PER_CYCLE + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_ITER - 1);

  state_e               state;
  logic [WIDTH+1:0]     a_reg;
  logic [BS_W-1:0]      b_sh;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   acc_next;
  logic [CNT_W-1:0]     cnt;
  logic                 accept;
  logic [WIDTH+1:0]     a_ext_in;
  logic [BS_W-2:0]      b_ext_in;
  logic [2:0]           triple [PP_PER_CYCLE];
  logic [WIDTH+2:0]     mult   [PP_PER_CYCLE];

  assign accept   = start && (state != RUN);
  assign a_ext_in = {{2{signed_mode & a[WIDTH-1]}}, a};
  assign b_ext_in = {{(BS_W-1-WIDTH){signed_mode & b[WIDTH-1]}}, b};

  // Slots beyond the last real digit (short final iteration) contribute zero
  for (genvar k = 0; k < PP_PER_CYCLE; k++) begin : g_slot
    assign triple[k] = (int'(cnt) * PP_PER_CYCLE + k < DIGITS) ? b_sh[2*k+2 -: 3] : 3'b000;

    booth_r4_enc #(
      .WIDTH(WIDTH)
    ) u_enc (
      .triple   (triple[k]),
      .a_ext    (a_reg),
      .multiple (mult[k])
    );
  end

  // Multiples are weighted by 4^digit; the sum wraps modulo 2^(2*WIDTH)
  always_comb begin
    acc_next = acc;
    for (int k = 0; k < PP_PER_CYCLE; k++) begin
      acc_next = acc_next
               + ({{(WIDTH-3){mult[k][WIDTH+2]}}, mult[k]} << (2 * (int'(cnt) * PP_PER_CYCLE + k)));
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state   <= IDLE;
      a_reg   <= '0;
      b_sh    <= '0;
      acc     <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        a_reg <= a_ext_in;
        b_sh  <= {b_ext_in, 1'b0};
        acc   <= '0;
        cnt   <= '0;
        busy  <= 1'b1;
        state <= RUN;
      end else begin
        case (state)
          RUN: begin
            acc  <= acc_next;
            cnt  <= cnt + 1'b1;
            b_sh <= {{(2*PP_PER_CYCLE){b_sh[BS_W-1]}}, b_sh[BS_W-1:2*PP_PER_CYCLE]};
            if (cnt == LAST) begin
              product <= acc_next;
              done    <= 1'b1;
              busy    <= 1'b0;
              state   <= DONE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_booth_mul_seq.sv
// tb/tb_booth_mul_seq.sv - directed and model-checked bench for booth_mul_seq
module tb_booth_mul_seq;

  logic        clk;
  logic        clr_n;

  logic        start32, sm32, busy32, done32;
  logic [31:0] a32, b32;
  logic [63:0] prod32;

  logic        start8, sm8, busy8, done8;
  logic [7:0]  a8, b8;
  logic [15:0] prod8;

  int n_checks;
  int n_fail;
  int cyc;
  int done_cnt32;
  int idle_cnt32;
  int overlap32;
  int overlap8;

  booth_mul_seq #(.WIDTH(32), .PP_PER_CYCLE(1)) u_dut32 (
    .clk(clk), .clr_n(clr_n), .start(start32), .signed_mode(sm32),
    .a(a32), .b(b32), .busy(busy32), .done(done32), .product(prod32)
  );

  booth_mul_seq #(.WIDTH(8), .PP_PER_CYCLE(2)) u_dut8 (
    .clk(clk), .clr_n(clr_n), .start(start8), .signed_mode(sm8),
    .a(a8), .b(b8), .busy(busy8), .done(done8), .product(prod8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done32) done_cnt32 <= done_cnt32 + 1;
    if (!busy32) idle_cnt32 <= idle_cnt32 + 1;
    if (busy32 && done32) overlap32 <= overlap32 + 1;
    if (busy8 && done8) overlap8 <= overlap8 + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done32(output int edges);
    edges = 0;
    while (!done32 && edges < 40) begin
      tick();
      edges++;
    end
    if (!done32) edges = -1;
  endtask

  task automatic wait_done8(output int edges);
    edges = 0;
    while (!done8 && edges < 10) begin
      tick();
      edges++;
    end
    if (!done8) edges = -1;
  endtask

  task automatic run32(input string tag, input logic sm, input logic [31:0] x, input logic [31:0] y,
                       input logic [63:0] exp);
    int e;
    int d0;
    d0 = done_cnt32;
    sm32 = sm; a32 = x; b32 = y; start32 = 1'b1;
    tick();
    start32 = 1'b0; a32 = 32'hDEAD_BEEF; b32 = 32'h1234_5678; sm32 = ~sm;
    check({tag, "_busy"}, {63'd0, busy32}, 64'd1);
    wait_done32(e);
    check({tag, "_lat"}, 64'(e), 64'd17);
    check({tag, "_prod"}, prod32, exp);
    check({tag, "_busy_at_done"}, {63'd0, busy32}, 64'd0);
    tick();
    check({tag, "_one_done"}, 64'(done_cnt32 - d0), 64'd1);
  endtask

  task automatic run8(input string tag, input logic sm, input logic [7:0] x, input logic [7:0] y,
                      input logic [15:0] exp);
    int e;
    sm8 = sm; a8 = x; b8 = y; start8 = 1'b1;
    tick();
    start8 = 1'b0; a8 = 8'hA5; b8 = 8'h5A;
    wait_done8(e);
    check({tag, "_lat"}, 64'(e), 64'd3);
    check({tag, "_prod"}, {48'd0, prod8}, {48'd0, exp});
  endtask

  function automatic logic [15:0] model8(input logic sm, input logic [7:0] x, input logic [7:0] y);
    int sx;
    int sy;
    sx = sm ? int'($signed(x)) : int'(x);
    sy = sm ? int'($signed(y)) : int'(y);
    return 16'(sx * sy);
  endfunction

  initial begin
    int e;
    int d0;
    int c1;
    int i0;
    logic [7:0] rx;
    logic [7:0] ry;
    logic       rs;

    n_checks = 0; n_fail = 0; cyc = 0;
    done_cnt32 = 0; idle_cnt32 = 0; overlap32 = 0; overlap8 = 0;
    clr_n = 1'b0;
    start32 = 1'b0; sm32 = 1'b0; a32 = '0; b32 = '0;
    start8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0;
    repeat (3) tick();
    check("rst_busy", {63'd0, busy32}, 64'd0);
    check("rst_done", {63'd0, done32}, 64'd0);
    check("rst_prod", prod32, 64'd0);
    check("rst_prod8", {48'd0, prod8}, 64'd0);
    clr_n = 1'b1;
    tick();

    run32("s_m1xm1", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001);

    // Abort mid-RUN with an asynchronous reset
    d0 = done_cnt32;
    sm32 = 1'b1; a32 = 32'd3; b32 = 32'd5; start32 = 1'b1;
    tick();
    start32 = 1'b0;
    repeat (5) tick();
    #2 clr_n = 1'b0;
    #1;
    check("abort_busy", {63'd0, busy32}, 64'd0);
    check("abort_prod", prod32, 64'd0);
    tick(); tick();
    clr_n = 1'b1;
    repeat (25) tick();
    check("abort_no_done", 64'(done_cnt32 - d0), 64'd0);
    check("abort_prod_hold", prod32, 64'd0);

    run32("s_min_x1", 1'b1, 32'h8000_0000, 32'h0000_0001, 64'hFFFF_FFFF_8000_0000);
    run32("u_max_sq", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    run32("u_min_sq", 1'b0, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);

    // Start while busy is ignored
    d0 = done_cnt32;
    sm32 = 1'b0; a32 = 32'd3; b32 = 32'd4; start32 = 1'b1;
    tick();
    start32 = 1'b0;
    repeat (3) tick();
    a32 = 32'd5; b32 = 32'd7; start32 = 1'b1;
    tick();
    start32 = 1'b0;
    wait_done32(e);
    check("ign_lat", 64'(e), 64'd13);
    check("ign_prod", prod32, 64'd12);
    repeat (25) tick();
    check("ign_one_done", 64'(done_cnt32 - d0), 64'd1);
    check("ign_prod_hold", prod32, 64'd12);

    // Back-to-back with start held high
    sm32 = 1'b1; a32 = 32'd2; b32 = 32'd3; start32 = 1'b1;
    tick();
    a32 = 32'hFFFF_FFFC; b32 = 32'd6;
    wait_done32(e);
    check("b2b_lat1", 64'(e), 64'd17);
    check("b2b_prod1", prod32, 64'd6);
    c1 = cyc;
    i0 = idle_cnt32;
    tick();
    check("b2b_busy_again", {63'd0, busy32}, 64'd1);
    check("b2b_prod1_hold", prod32, 64'd6);
    wait_done32(e);
    start32 = 1'b0;
    check("b2b_gap", 64'(cyc - c1), 64'd18);
    check("b2b_prod2", prod32, 64'hFFFF_FFFF_FFFF_FFE8);
    check("b2b_idle_cycles", 64'(idle_cnt32 - i0), 64'd1);
    tick();

    run8("w8_s_minsq", 1'b1, 8'h80, 8'h80, 16'h4000);
    run8("w8_u_maxsq", 1'b0, 8'hFF, 8'hFF, 16'hFE01);
    run8("w8_s_minxmax", 1'b1, 8'h80, 8'h7F, 16'hC080);
    run8("w8_u_128x2", 1'b0, 8'h80, 8'h02, 16'h0100);
    run8("w8_s_m1xm1", 1'b1, 8'hFF, 8'hFF, 16'h0001);
    for (int n = 0; n < 10000; n++) begin
      rx = 8'($urandom);
      ry = 8'($urandom);
      rs = 1'($urandom);
      run8("w8_rand", rs, rx, ry, model8(rs, rx, ry));
    end
    tick();

    check("excl32", 64'(overlap32), 64'd0);
    check("excl8", 64'(overlap8), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
